// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/bubble/flush controller with interlock watchdog.
// Define PIPE_PERF_CNT_EN to build the saturating stall performance counters.
module pipe_hold_ctrl #(
    parameter int MAX_ILOCK = 4,
    parameter int CNTW      = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall_req,
    input  logic            mem_busy,
    input  logic            redirect,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_we,
    output logic            idex_bubble,
    output logic            exmem_we,
    output logic            hazard_err,
    output logic [1:0]      state_o,
    output logic [CNTW-1:0] ilock_cycles,
    output logic [CNTW-1:0] mwait_cycles,
    output logic [CNTW-1:0] flush_count
);
    typedef enum logic [1:0] {RUN = 2'd0, ILOCK = 2'd1, MWAIT = 2'd2} state_t;
    state_t     state_q, state_d;
    logic [3:0] ilock_cnt_q, ilock_cnt_d;
    logic       hazard_err_q, hazard_err_d;
    logic       wd_trip, accept;
    assign wd_trip = (ilock_cnt_q == 4'(MAX_ILOCK)) && stall_req && !mem_busy && !redirect;
    assign accept  = stall_req && !mem_busy && !redirect && !wd_trip;
    // Reset forces the stall pattern immediately, independent of the clock.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        if (!reset_n || accept) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
        end else if (redirect) begin
            ifid_flush = 1'b1;
        end
    end
    always_comb begin
        state_d      = mem_busy ? MWAIT : accept ? ILOCK : RUN;
        ilock_cnt_d  = mem_busy ? ilock_cnt_q : accept ? ilock_cnt_q + 4'd1 : 4'd0;
        hazard_err_d = hazard_err_q || wd_trip;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            ilock_cnt_q  <= 4'd0;
            hazard_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ilock_cnt_q  <= ilock_cnt_d;
            hazard_err_q <= hazard_err_d;
        end
    end
    assign state_o    = state_q;
    assign hazard_err = hazard_err_q;
`ifdef PIPE_PERF_CNT_EN
    logic [CNTW-1:0] ilock_cycles_q, mwait_cycles_q, flush_count_q;
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ilock_cycles_q <= '0;
            mwait_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (accept && ilock_cycles_q != '1)
                ilock_cycles_q <= ilock_cycles_q + CNTW'(1);
            if (mem_busy && mwait_cycles_q != '1)
                mwait_cycles_q <= mwait_cycles_q + CNTW'(1);
            if (redirect && !mem_busy && flush_count_q != '1)
                flush_count_q <= flush_count_q + CNTW'(1);
        end
    end
    assign ilock_cycles = ilock_cycles_q;
    assign mwait_cycles = mwait_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign ilock_cycles = '0;
    assign mwait_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb_pipe_hold_ctrl: directed checks of pipe_hold_ctrl enables, watchdog, state and counters.
module tb_pipe_hold_ctrl;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [5:0] NORM  = 6'b110101;
    localparam logic [5:0] STALL = 6'b000111;
    localparam logic [5:0] FRZ   = 6'b000000;
    localparam logic [5:0] FLUSH = 6'b111101;
    logic       clock, reset_n, stall_req, mem_busy, redirect;
    logic       pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, hazard_err;
    logic [1:0] state_o;
    logic [3:0] ilock_cycles, mwait_cycles, flush_count;
    logic [5:0] en;
    int         tests, fails;
    assign en = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we};
    pipe_hold_ctrl #(.MAX_ILOCK(4), .CNTW(4)) dut (
        .clock(clock), .reset_n(reset_n), .stall_req(stall_req), .mem_busy(mem_busy),
        .redirect(redirect), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
        .hazard_err(hazard_err), .state_o(state_o), .ilock_cycles(ilock_cycles),
        .mwait_cycles(mwait_cycles), .flush_count(flush_count)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Drive one cycle from a negedge, check enables mid-cycle, end on the next negedge.
    task automatic cyc(input logic s, input logic m, input logic r, input logic [5:0] exp, input string tag);
        stall_req = s;
        mem_busy  = m;
        redirect  = r;
        #1 chk(tag, 32'(en), 32'(exp));
        @(posedge clock);
        @(negedge clock);
    endtask
    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        stall_req = 1'b0;
        mem_busy = 1'b0;
        redirect = 1'b0;
        #2;
        chk("rst_en", 32'(en), 32'(STALL));
        chk("rst_state", 32'(state_o), 0);
        chk("rst_hzd", 32'(hazard_err), 0);
        chk("rst_cnt", {20'd0, ilock_cycles, mwait_cycles, flush_count}, 0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        // single load-use right after reset release
        cyc(1, 0, 0, STALL, "lu_stall");
        chk("lu_state_ilock", 32'(state_o), 1);
        cyc(0, 0, 0, NORM, "lu_adv");
        chk("lu_state_run", 32'(state_o), 0);
        chk("lu_icyc", 32'(ilock_cycles), PERF ? 1 : 0);
        // watchdog: 4 accepted, 5th released, 6th stalls again
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, STALL, "wd_stall");
        chk("wd_hzd_pre", 32'(hazard_err), 0);
        cyc(1, 0, 0, NORM, "wd_trip");
        chk("wd_hzd", 32'(hazard_err), 1);
        chk("wd_state_run", 32'(state_o), 0);
        cyc(1, 0, 0, STALL, "wd_restall");
        chk("wd_state_ilock", 32'(state_o), 1);
        chk("wd_icyc", 32'(ilock_cycles), PERF ? 6 : 0);
        cyc(0, 0, 0, NORM, "wd_end");
        // freeze during interlock: count holds at 2, so only two more stalls fit
        cyc(1, 0, 0, STALL, "fz_s1");
        cyc(1, 0, 0, STALL, "fz_s2");
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, FRZ, "fz_freeze");
        chk("fz_state_mwait", 32'(state_o), 2);
        cyc(1, 0, 0, STALL, "fz_s3");
        cyc(1, 0, 0, STALL, "fz_s4");
        cyc(1, 0, 0, NORM, "fz_trip");
        chk("fz_mcyc", 32'(mwait_cycles), PERF ? 3 : 0);
        chk("fz_icyc", 32'(ilock_cycles), PERF ? 10 : 0);
        chk("fz_hzd_sticky", 32'(hazard_err), 1);
        // redirect: with mem_busy it freezes; alone it flushes and clears the count
        cyc(1, 0, 0, STALL, "rd_pre");
        cyc(1, 1, 1, FRZ, "rd_busy");
        chk("rd_busy_fc", 32'(flush_count), 0);
        chk("rd_busy_state", 32'(state_o), 2);
        cyc(1, 0, 1, FLUSH, "rd_flush");
        chk("rd_fc", 32'(flush_count), PERF ? 1 : 0);
        chk("rd_state", 32'(state_o), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, STALL, "rd_cnt_clr");
        cyc(1, 0, 0, NORM, "rd_trip");
        chk("rd_icyc", 32'(ilock_cycles), PERF ? 15 : 0);
        cyc(1, 0, 0, STALL, "sat_stall");
        chk("sat_icyc", 32'(ilock_cycles), PERF ? 15 : 0);
        cyc(0, 0, 0, NORM, "sat_end");
        // async reset mid-MWAIT
        cyc(0, 1, 0, FRZ, "ar_busy");
        chk("ar_state_mwait", 32'(state_o), 2);
        chk("ar_mcyc", 32'(mwait_cycles), PERF ? 5 : 0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_en", 32'(en), 32'(STALL));
        chk("ar_state", 32'(state_o), 0);
        chk("ar_hzd", 32'(hazard_err), 0);
        chk("ar_cnt", {20'd0, ilock_cycles, mwait_cycles, flush_count}, 0);
        @(posedge clock);
        @(negedge clock);
        mem_busy = 1'b0;
        reset_n = 1'b1;
        cyc(0, 0, 0, NORM, "ar_rel");
        chk("ar_rel_state", 32'(state_o), 0);
        chk("ar_rel_cnt", {20'd0, ilock_cycles, mwait_cycles, flush_count}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
